uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter DBIT, default 8, number of data bits per frame (legal range 5..8).
REQ-002 SHALL have parameter SB_TICK, default 16, number of s_tick pulses in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port s_tick  input  1  16x oversampling enable from the baud rate generator's max_tick; one clk cycle wide.
REQ-006 SHALL have port tx_start  input  1  request to send din; sampled only in IDLE.
REQ-007 SHALL have port din  input  8  byte to send; only bits [DBIT-1:0] are transmitted.
REQ-008 SHALL have port tx  output  1  serial line, registered, idle high.
REQ-009 SHALL have port tx_busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port tx_done_tick  output  1  one-clk pulse marking the end of a frame.

Function
REQ-011 SHALL use FSM states IDLE, START, DATA, STOP, with a 5-bit tick counter s_cnt, a 3-bit bit counter n_cnt and a DBIT-wide shift register b_reg.
REQ-012 In IDLE, tx_start=1 SHALL at the next edge latch din into b_reg, clear s_cnt, and enter START; s_tick is not required.
REQ-013 In IDLE, tx SHALL be 1; tx_start=0 SHALL leave all state unchanged.
REQ-014 In START, tx SHALL be 0; each s_tick SHALL increment s_cnt; an s_tick with s_cnt=15 SHALL clear s_cnt and n_cnt and enter DATA.
REQ-015 In DATA, tx SHALL equal b_reg[0] (LSB first); an s_tick with s_cnt=15 SHALL clear s_cnt and shift b_reg right by one.
REQ-016 In DATA, when that 15th-count s_tick occurs with n_cnt=DBIT-1, the FSM SHALL enter STOP; otherwise n_cnt SHALL increment.
REQ-017 In STOP, tx SHALL be 1; an s_tick with s_cnt=SB_TICK-1 SHALL return the FSM to IDLE.
REQ-018 tx_done_tick SHALL be registered and high for exactly the one clk cycle following the STOP-to-IDLE edge.
REQ-019 tx SHALL be a registered output, changing on the same edge as the state change that defines its value (no combinational glitches).
REQ-020 Clock cycles without s_tick SHALL leave s_cnt, n_cnt, b_reg and state unchanged (except the IDLE acceptance in REQ-012).
REQ-021 tx_start asserted in any state other than IDLE SHALL be ignored and not queued.
REQ-022 din changes after acceptance SHALL NOT affect the frame in progress.
REQ-023 tx_start asserted in the cycle where tx_done_tick=1 (FSM already in IDLE) SHALL be accepted, giving back-to-back frames with no extra idle time.
REQ-024 With s_tick high every cycle, a frame SHALL last exactly 16*(1+DBIT)+SB_TICK cycles from entry into START to the return to IDLE.

Reset
REQ-025 On reset assertion, the block SHALL immediately force state=IDLE, s_cnt=0, n_cnt=0, b_reg=0, tx=1, tx_busy=0 and tx_done_tick=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no tx_done_tick; the first tx_start after release SHALL start a fresh frame.

Verification
REQ-027 Defaults, s_tick every cycle, din=0xA5, 1-cycle tx_start: the bench SHALL observe these tx levels in successive 16-cycle windows: 0, 1,0,1,0,0,1,0,1, 1 (each held 16 cycles), then tx_done_tick for 1 cycle, with tx_busy high for 160 cycles.
REQ-028 s_tick from a baud rate generator with M=4, din=0x3C: each bit SHALL last 64 cycles, and the received LSB-first bits SHALL be 0,0,1,1,1,1,0,0.
REQ-029 tx_start pulsed at cycle 50 of the 0xA5 frame with din=0xFF: the bench SHALL observe the frame unchanged, exactly one tx_done_tick, and no second frame.
REQ-030 tx_start held high continuously, din=0x55: frames SHALL follow back-to-back, the next START beginning on the edge after tx_done_tick, with no idle-high gap beyond the stop period.
REQ-031 Reset asserted during DATA bit 3: tx SHALL go to 1 asynchronously and tx_busy to 0, with no tx_done_tick; after release a new 0x81 frame SHALL be transmitted correctly.
REQ-032 SB_TICK=32 with din=0x00: the stop-high period SHALL last 32 ticks, and the frame length SHALL be 176 cycles with s_tick every cycle.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART transmitter: frames din as start bit, DBIT data bits LSB first, and a stop period,
// timed by a 16x oversampling tick from the baud rate generator.
module uart_transmitter #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [4:0] TICK_LAST = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DBIT - 1);

  logic [1:0]      r_state, w_state_next;
  logic [4:0]      r_s_cnt, w_s_cnt_next;
  logic [2:0]      r_n_cnt, w_n_cnt_next;
  logic [DBIT-1:0] r_b_reg, w_b_reg_next;
  logic            r_tx, w_tx_next;
  logic            r_done, w_done_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_s_cnt <= '0;
      r_n_cnt <= '0;
      r_b_reg <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_s_cnt <= w_s_cnt_next;
      r_n_cnt <= w_n_cnt_next;
      r_b_reg <= w_b_reg_next;
      r_tx    <= w_tx_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_s_cnt_next = r_s_cnt;
    w_n_cnt_next = r_n_cnt;
    w_b_reg_next = r_b_reg;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (tx_start) begin
          w_state_next = START;
          w_s_cnt_next = '0;
          w_b_reg_next = din[DBIT-1:0];
        end
      end
      START: begin
        if (s_tick) begin
          if (r_s_cnt == TICK_LAST) begin
            w_state_next = DATA;
            w_s_cnt_next = '0;
            w_n_cnt_next = '0;
          end else begin
            w_s_cnt_next = r_s_cnt + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_s_cnt == TICK_LAST) begin
            w_s_cnt_next = '0;
            w_b_reg_next = r_b_reg >> 1;
            if (r_n_cnt == BIT_LAST) begin
              w_state_next = STOP;
            end else begin
              w_n_cnt_next = r_n_cnt + 3'd1;
            end
          end else begin
            w_s_cnt_next = r_s_cnt + 5'd1;
          end
        end
      end
      default: begin
        if (s_tick) begin
          if (r_s_cnt == STOP_LAST) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_s_cnt_next = r_s_cnt + 5'd1;
          end
        end
      end
    endcase

    // Line level follows the next state so tx changes on the same edge as the state.
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_b_reg_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  assign tx           = r_tx;
  assign tx_busy      = (r_state != IDLE);
  assign tx_done_tick = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: table of whole frames checked window by window,
// plus hand-written sequences for ignored starts, back-to-back frames and mid-frame reset.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] din;
  logic       tx, tx_busy, tx_done_tick;
  logic       tx32, busy32, done32;

  int  n_chk  = 0;
  int  n_pass = 0;
  int  div    = 1;
  int  tcnt   = 0;
  bit  sel32  = 1'b0;

  always #5 clk = ~clk;

  uart_transmitter dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .tx_start     (tx_start),
    .din          (din),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  uart_transmitter #(.DBIT(8), .SB_TICK(32)) dut32 (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .tx_start     (tx_start),
    .din          (din),
    .tx           (tx32),
    .tx_busy      (busy32),
    .tx_done_tick (done32)
  );

  typedef struct {
    logic [7:0] din;
    logic [9:0] line;   // bit w = expected tx level in window w (start, d0..d7, stop)
    int         dv;     // clk cycles per s_tick
    int         stop;   // stop length in ticks
    bit         use32;
  } vec_t;

  vec_t vecs[4];

  function automatic logic cur_tx();
    return sel32 ? tx32 : tx;
  endfunction

  function automatic logic cur_busy();
    return sel32 ? busy32 : tx_busy;
  endfunction

  function automatic logic cur_done();
    return sel32 ? done32 : tx_done_tick;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    tcnt   = (tcnt + 1) % div;
    s_tick = (tcnt == div - 1);
  endtask

  task automatic start_frame(input logic [7:0] d);
    din      = d;
    tx_start = 1'b1;
    tcnt     = div - 1;
    s_tick   = 1'b1;
  endtask

  task automatic watch(input logic [9:0] line, input int stoplen, input bit hold,
                       input int poke_at, input string tag);
    int k;
    int errs;
    int len;
    k = 0;
    for (int w = 0; w < 10; w++) begin
      errs = 0;
      len  = (w == 9) ? stoplen * div : 16 * div;
      for (int c = 0; c < len; c++) begin
        next_cycle();
        k++;
        if (cur_tx() !== line[w] || cur_busy() !== 1'b1 || cur_done() !== 1'b0) errs++;
        if (k == 1 && !hold) begin
          tx_start = 1'b0;
          din      = ~din;
        end
        if (poke_at != 0 && k == poke_at) begin
          tx_start = 1'b1;
          din      = 8'hFF;
        end
        if (poke_at != 0 && k == poke_at + 1) tx_start = 1'b0;
      end
      check($sformatf("%s window%0d bad cycles", tag, w), errs, 0);
    end
    next_cycle();
    check($sformatf("%s end {done,busy,tx}", tag),
          {29'd0, cur_done(), cur_busy(), cur_tx()}, 32'b101);
  endtask

  task automatic idle(input int n, input string tag);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      next_cycle();
      if (cur_tx() !== 1'b1 || cur_busy() !== 1'b0 || cur_done() !== 1'b0) errs++;
    end
    check($sformatf("%s idle bad cycles", tag), errs, 0);
  endtask

  initial begin
    int errs;
    vecs[0] = '{din: 8'hA5, line: 10'b1_10100101_0, dv: 1, stop: 16, use32: 1'b0};
    vecs[1] = '{din: 8'h3C, line: 10'b1_00111100_0, dv: 4, stop: 16, use32: 1'b0};
    vecs[2] = '{din: 8'h81, line: 10'b1_10000001_0, dv: 1, stop: 16, use32: 1'b0};
    vecs[3] = '{din: 8'h00, line: 10'b1_00000000_0, dv: 1, stop: 32, use32: 1'b1};

    reset    = 1'b1;
    tx_start = 1'b0;
    din      = 8'h00;
    s_tick   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset {done,busy,tx}", {29'd0, tx_done_tick, tx_busy, tx}, 32'b001);
    check("reset dut32 {done,busy,tx}", {29'd0, done32, busy32, tx32}, 32'b001);
    reset = 1'b0;
    idle(5, "post-reset");

    for (int v = 0; v < 4; v++) begin
      div   = vecs[v].dv;
      sel32 = vecs[v].use32;
      start_frame(vecs[v].din);
      watch(vecs[v].line, vecs[v].stop, 1'b0, 0, $sformatf("vec%0d", v));
      idle(150, $sformatf("vec%0d", v));
    end
    div   = 1;
    sel32 = 1'b0;

    // Start request mid-frame with new data must be neither honoured nor queued.
    start_frame(8'hA5);
    watch(10'b1_10100101_0, 16, 1'b0, 50, "ignored-start");
    idle(40, "ignored-start");

    // tx_start held: second frame begins on the edge after tx_done_tick.
    start_frame(8'h55);
    watch(10'b1_01010101_0, 16, 1'b1, 0, "b2b-1");
    watch(10'b1_01010101_0, 16, 1'b1, 0, "b2b-2");
    tx_start = 1'b0;
    idle(30, "b2b");

    // Reset during DATA bit 3 of 0xA5 (bit 3 is 0, so the release to idle-high is visible).
    start_frame(8'hA5);
    for (int i = 1; i <= 70; i++) begin
      next_cycle();
      if (i == 1) tx_start = 1'b0;
    end
    check("pre-reset {busy,tx}", {30'd0, tx_busy, tx}, 32'b10);
    #3;
    reset = 1'b1;
    #1;
    check("async reset {done,busy,tx}", {29'd0, tx_done_tick, tx_busy, tx}, 32'b001);
    errs = 0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      if (tx_done_tick !== 1'b0 || tx !== 1'b1 || tx_busy !== 1'b0) errs++;
    end
    check("held reset bad cycles", errs, 0);
    reset = 1'b0;
    idle(3, "after-reset");
    start_frame(8'h81);
    watch(10'b1_10000001_0, 16, 1'b0, 0, "post-reset-81");
    idle(10, "final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
